tpu_job_sched: RTL

Job scheduler in front of the TPU top level. Accepts matrix-job descriptors (job ID plus weight/data SRAM base addresses) from the host-side command path through a valid/ready queue. Sequences them one at a time onto the TPU: presents the base addresses, pulses tpu_start, then waits for tpu_done or a timeout. Reports each job's completion with a status on a valid/ready completion channel.

---
 rtl/tpu_job_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tpu_job_sched.sv
// rtl/tpu_job_sched.sv - job descriptor queue plus one-at-a-time TPU sequencer with timeout
// Jobs are launched in FIFO order; each produces exactly one completion record unless reset intervenes.
module tpu_job_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int JOB_ID_WIDTH   = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [JOB_ID_WIDTH-1:0] job_id,
    input  logic [ADDR_WIDTH-1:0]   job_base_w,
    input  logic [ADDR_WIDTH-1:0]   job_base_d,
    output logic                    tpu_start,
    input  logic                    tpu_done,
    output logic [ADDR_WIDTH-1:0]   tpu_base_w,
    output logic [ADDR_WIDTH-1:0]   tpu_base_d,
    output logic                    cmpl_valid,
    input  logic                    cmpl_ready,
    output logic [JOB_ID_WIDTH-1:0] cmpl_id,
    output logic [1:0]              cmpl_status,
    output logic                    busy,
    output logic                    err_spurious,
    output logic [CNT_WIDTH-1:0]    jobs_done
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]          FULL    = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]          OCC_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]        PTR_ONE = PW'(1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [1:0]           ST_OK      = 2'b00;
    localparam logic [1:0]           ST_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, REPORT} state_t;

    state_t                  state;
    logic [JOB_ID_WIDTH-1:0] q_id [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_w  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_d  [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [PW:0]             count;
    logic [JOB_ID_WIDTH-1:0] cur_id;
    logic [ADDR_WIDTH-1:0]   cur_w, cur_d;
    logic [CNT_WIDTH-1:0]    tout_cnt;
    logic                    push, pop;

    // Ready comes from the registered occupancy only, so a full queue stays closed even while popping.
    assign job_ready = (count != FULL);
    assign push      = job_valid && job_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr] <= job_id;
            q_w[wr_ptr]  <= job_base_w;
            q_d[wr_ptr]  <= job_base_d;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + OCC_ONE;
                2'b01:   count <= count - OCC_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state        <= IDLE;
            cur_id       <= '0;
            cur_w        <= '0;
            cur_d        <= '0;
            tout_cnt     <= '0;
            tpu_start    <= 1'b0;
            tpu_base_w   <= '0;
            tpu_base_d   <= '0;
            cmpl_valid   <= 1'b0;
            cmpl_id      <= '0;
            cmpl_status  <= ST_OK;
            jobs_done    <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (tpu_done && state != RUN) err_spurious <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_id <= q_id[rd_ptr];
                        cur_w  <= q_w[rd_ptr];
                        cur_d  <= q_d[rd_ptr];
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    tpu_base_w <= cur_w;
                    tpu_base_d <= cur_d;
                    tout_cnt   <= '0;
                    tpu_start  <= 1'b1;
                    state      <= START;
                end
                START: begin
                    tpu_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    tout_cnt <= tout_cnt + CNT_ONE;
                    // A done arriving on the final allowed cycle still counts as success.
                    if (tpu_done) begin
                        cmpl_valid  <= 1'b1;
                        cmpl_id     <= cur_id;
                        cmpl_status <= ST_OK;
                        state       <= REPORT;
                    end else if (tout_cnt == TO_LAST) begin
                        cmpl_valid  <= 1'b1;
                        cmpl_id     <= cur_id;
                        cmpl_status <= ST_TIMEOUT;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (cmpl_ready) begin
                        cmpl_valid <= 1'b0;
                        jobs_done  <= jobs_done + CNT_ONE;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
